// File: rtl/axi_pad_pkg.sv
// Shared types and constants for the AXI pad stage and its read-latency monitor.
package axi_pad_pkg;

  localparam logic [31:0] PadNoOverride = 32'hFFFF_FFFF;
  localparam logic [31:0] LatSat        = 32'hFFFF_FFFE;
  localparam int unsigned IdW           = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    PUBLISH = 2'd2
  } lat_mon_state_e;

  // Snooped slave-side channel views: only the fields the monitor looks at.
  typedef struct packed {
    logic [IdW-1:0] id;
  } ar_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic           last;
  } r_chan_t;

  typedef struct packed {
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_slv_t;

  typedef struct packed {
    logic     ar_ready;
    r_chan_t  r;
    logic     r_valid;
  } resp_slv_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

endpackage

// File: rtl/axi_rd_lat_mon.sv
// Passive AR->R-last latency monitor; publishes window max + margin for one
// cycle to drive axi_pad's pad_cycles_i, otherwise signals no override.
module axi_rd_lat_mon
  import axi_pad_pkg::*;
#(
  parameter int unsigned WindowTxns = 16,
  parameter int unsigned Margin     = 2,
  parameter type         req_t      = req_slv_t,
  parameter type         resp_t     = resp_slv_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        clear_i,
  input  req_t        mon_req_i,
  input  resp_t       mon_resp_i,
  output logic [31:0] pad_cycles_o,
  output logic [31:0] max_lat_o,
  output logic [31:0] txn_cnt_o,
  output logic [31:0] skipped_o
);

  localparam int unsigned CntW = $clog2(WindowTxns + 1);

  lat_mon_state_e state_q;
  logic [IdW-1:0] id_q;
  logic [31:0]    lat_q, lat_d;
  logic [31:0]    max_q, max_d;
  logic [CntW-1:0] win_q, win_d;
  logic [31:0]    txn_q, skip_q;
  logic [31:0]    pub_q, pub_d;
  logic [32:0]    pub_sum;
  logic           ar_hs, rl_hs, win_full;

  always_comb begin
    ar_hs    = mon_req_i.ar_valid && mon_resp_i.ar_ready;
    rl_hs    = mon_resp_i.r_valid && mon_req_i.r_ready && mon_resp_i.r.last
               && (mon_resp_i.r.id == id_q);
    lat_d    = (lat_q == LatSat) ? lat_q : lat_q + 32'd1;
    max_d    = (lat_q > max_q) ? lat_q : max_q;
    win_d    = win_q + CntW'(1);
    win_full = (win_d == CntW'(WindowTxns));
    // 33-bit sum so the margin can never wrap onto the no-override code.
    pub_sum  = {1'b0, max_d} + 33'(Margin);
    pub_d    = (pub_sum > {1'b0, LatSat}) ? LatSat : pub_sum[31:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      lat_q   <= '0;
      max_q   <= '0;
      win_q   <= '0;
      txn_q   <= '0;
      skip_q  <= '0;
      pub_q   <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      lat_q   <= '0;
      max_q   <= '0;
      win_q   <= '0;
      txn_q   <= '0;
      skip_q  <= '0;
    end else if (!en_i) begin
      // A publish already on the output still retires its window.
      state_q <= IDLE;
      lat_q   <= '0;
      if (state_q == PUBLISH) begin
        max_q <= '0;
        win_q <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_hs) begin
            id_q    <= mon_req_i.ar.id;
            lat_q   <= 32'd1;
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (rl_hs) begin
            max_q <= max_d;
            win_q <= win_d;
            txn_q <= sat_inc32(txn_q);
            if (win_full) begin
              pub_q   <= pub_d;
              state_q <= PUBLISH;
              if (ar_hs) skip_q <= sat_inc32(skip_q);
            end else if (ar_hs) begin
              id_q  <= mon_req_i.ar.id;
              lat_q <= 32'd1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            lat_q <= lat_d;
            if (ar_hs) skip_q <= sat_inc32(skip_q);
          end
        end
        PUBLISH: begin
          max_q <= '0;
          win_q <= '0;
          if (ar_hs) begin
            id_q    <= mon_req_i.ar.id;
            lat_q   <= 32'd1;
            state_q <= MEASURE;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pad_cycles_o = (state_q == PUBLISH) ? pub_q : PadNoOverride;
  assign max_lat_o    = max_q;
  assign txn_cnt_o    = txn_q;
  assign skipped_o    = skip_q;

endmodule
